vram_port_arbiter: RTL and testbench
====================================

Name: vram_port_arbiter

Overview:
- Shares the single VRAM BRAM port A (14-bit word address, 32-bit data, byte write enables) between two requesters: requester 0 is the AXI host path and requester 1 is the hardware fill/scroll engine.
- Round-robin arbitration, one BRAM access per cycle, pipelined reads with fixed BRAM latency, and read-data routing back to the issuing requester by tag.
- Sits between the AXI slave front-end / engine and the VRAM block RAM.

Parameters:
- ADDR_W, 14: BRAM word-address width.
- DATA_W, 32: data width; byte-enable width is DATA_W/8.
- READ_LAT, 2: cycles from the access cycle (sram_ena=1) to valid sram_douta; legal range 1..4.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESET  in  1  synchronous active-high reset.
- req0  in  1  host access request; held until granted.
- we0  in  DATA_W/8  host byte enables; 0 = read.
- addr0  in  ADDR_W  host word address.
- wdata0  in  DATA_W  host write data.
- gnt0  out  1  one-cycle pulse: host access issued this cycle.
- rvalid0  out  1  one-cycle pulse: rdata0 valid.
- rdata0  out  DATA_W  host read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as above, for the engine.
- sram_ena  out  1  BRAM enable.
- sram_wea  out  DATA_W/8  BRAM byte write enables.
- sram_addra  out  ADDR_W  BRAM address.
- sram_dina  out  DATA_W  BRAM write data.
- sram_douta  in  DATA_W  BRAM read data.

Behaviour:
- Reset: all outputs 0; read-tag pipeline cleared; last-granted pointer = 1, so the host wins the first tie.
- Reset mid-operation: in-flight reads are dropped with no rvalid; any pending grant is cancelled.
- All outputs are registered.
- Eligibility at each clock edge: elig_i = req_i & ~gnt_i. A requester granted in cycle C is masked in cycle C.
  - A requester must deassert req, or present its next request, on the edge that ends its gnt cycle.
  - Single-requester throughput is therefore 1 access per 2 cycles.
- Selection:
  - Only one eligible requester: grant it.
  - Both eligible: grant the one not equal to the last-granted pointer.
  - None eligible: idle.
- Grant cycle G: gnt_k=1, sram_ena=1, and sram_wea/addra/dina equal the values sampled from requester k at the edge starting G. The pointer updates to k.
- Idle cycle: sram_ena=0, sram_wea=0. addra/dina hold their last values.
- The two gnt outputs are never high in the same cycle.
- Reads (we_k==0):
  - A tag {valid, owner=k} enters a READ_LAT-deep shift register at cycle G.
  - In cycle G+READ_LAT the arbiter captures sram_douta into rdata_k and pulses rvalid_k.
- Writes (we_k!=0): no tag is issued and rvalid is never pulsed.
- Back-to-back accesses with alternating owners are fully pipelined: one access per cycle, and each read returns in issue order to its owner.
- rdata_k holds its last value between rvalid pulses.
- A read issued in the cycle after a write to the same address returns the newly written data. The BRAM is configured read-after-write across cycles; no bypass is needed.
- Widths:
  - Address passes unmodified, with no wrap or translation.
  - Byte enables pass straight to sram_wea.
- Starvation bound: a continuously requesting requester is granted within 2 cycles of becoming eligible.

Test Plan:
- Reset: after reset, hold req0=req1=0 for 5 cycles -> sram_ena=0, gnt0=gnt1=0, rvalid0=rvalid1=0, all data outputs 0.
- Host write then read:
  - req0, we0=4'hF, addr0=0x0010, wdata0=0xDEADBEEF -> gnt0 pulse; sram_wea=F, sram_addra=0x0010 that cycle.
  - Then a read of 0x0010 -> rvalid0 exactly READ_LAT=2 cycles after its gnt0, rdata0=0xDEADBEEF, rvalid1 stays 0.
- Simultaneous requests:
  - req0 and req1 both asserted from reset, both reads of distinct preloaded addresses (0x0001=0x11111111, 0x0002=0x22222222).
  - -> grants go host, engine, host, engine on consecutive cycles with sram_ena high every cycle.
  - -> rdata0=0x11111111 and rdata1=0x22222222 arrive on their own ports in issue order.
- Partial write: we1=4'b0010, wdata1=0x0000AB00 to an address holding 0x12345678, then a read -> 0x1234AB78.
- Single-requester rate: req1 held high continuously with no req0 -> gnt1 on alternating cycles only; sram_ena duty is 50%.
- Reset mid-flight: issue a read, assert S_AXI_ARESET in the next cycle -> no rvalid ever appears for that read; first post-reset tie grants the host.

Source files
------------

// File: rtl/vram_port_arbiter.sv
// Round-robin share of VRAM BRAM port A between host (0) and fill engine (1); grant is registered.
// Read data returns READ_LAT cycles after the grant cycle. Requesters hold req until gnt and are masked for that cycle.
module vram_port_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 2
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESET,
  input  logic                req0,
  input  logic [DATA_W/8-1:0] we0,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [DATA_W-1:0]   wdata0,
  output logic                gnt0,
  output logic                rvalid0,
  output logic [DATA_W-1:0]   rdata0,
  input  logic                req1,
  input  logic [DATA_W/8-1:0] we1,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   wdata1,
  output logic                gnt1,
  output logic                rvalid1,
  output logic [DATA_W-1:0]   rdata1,
  output logic                sram_ena,
  output logic [DATA_W/8-1:0] sram_wea,
  output logic [ADDR_W-1:0]   sram_addra,
  output logic [DATA_W-1:0]   sram_dina,
  input  logic [DATA_W-1:0]   sram_douta
);

  logic                elig0, elig1;
  logic                pick0, pick1;
  logic                last;
  logic [READ_LAT-1:0] tag_vld;
  logic [READ_LAT-1:0] tag_own;
  logic                ret0, ret1;

  // last==1 means the engine was granted most recently, so the host wins a tie
  always_comb begin
    elig0 = req0 & ~gnt0;
    elig1 = req1 & ~gnt1;
    pick0 = elig0 & (~elig1 | last);
    pick1 = elig1 & (~elig0 | ~last);
    ret0  = tag_vld[READ_LAT-1] & ~tag_own[READ_LAT-1];
    ret1  = tag_vld[READ_LAT-1] &  tag_own[READ_LAT-1];
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      last       <= 1'b1;
      sram_ena   <= 1'b0;
      sram_wea   <= '0;
      sram_addra <= '0;
      sram_dina  <= '0;
      tag_vld    <= '0;
      tag_own    <= '0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      gnt0     <= pick0;
      gnt1     <= pick1;
      sram_ena <= pick0 | pick1;
      if (pick0) begin
        sram_wea   <= we0;
        sram_addra <= addr0;
        sram_dina  <= wdata0;
        last       <= 1'b0;
      end else if (pick1) begin
        sram_wea   <= we1;
        sram_addra <= addr1;
        sram_dina  <= wdata1;
        last       <= 1'b1;
      end else begin
        sram_wea   <= '0;
      end

      // Tag stage 0 is live during the grant cycle; the last stage is live when douta is sampled
      for (int i = READ_LAT - 1; i > 0; i--) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_own[i] <= tag_own[i-1];
      end
      tag_vld[0] <= (pick0 & (we0 == '0)) | (pick1 & (we1 == '0));
      tag_own[0] <= pick1;

      rvalid0 <= ret0;
      rvalid1 <= ret1;
      if (ret0) rdata0 <= sram_douta;
      if (ret1) rdata1 <= sram_douta;
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: behavioural BRAM (one output register, READ_LAT=2) plus per-owner read scoreboards.
module tb_vram_port_arbiter;
  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 32;
  localparam int READ_LAT = 2;
  localparam int BE_W     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [BE_W-1:0]   we0 = '0, we1 = '0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              sram_ena;
  logic [BE_W-1:0]   sram_wea;
  logic [ADDR_W-1:0] sram_addra;
  logic [DATA_W-1:0] sram_dina;
  logic [DATA_W-1:0] sram_douta = '0;

  vram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .sram_ena(sram_ena), .sram_wea(sram_wea), .sram_addra(sram_addra),
    .sram_dina(sram_dina), .sram_douta(sram_douta)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  always @(posedge clk) begin
    if (sram_ena) begin
      for (int b = 0; b < BE_W; b++)
        if (sram_wea[b]) mem[sram_addra][8*b +: 8] <= sram_dina[8*b +: 8];
      sram_douta <= mem[sram_addra];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                gc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int n_chk = 0;
  int n_pass = 0;
  int ena_cnt = 0, rv0_cnt = 0, rv1_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("gnt_excl", 64'(gnt0 & gnt1), 64'd0);
    if (sram_ena) ena_cnt++;
    if (rvalid0) begin
      rv0_cnt++;
      if (q0.size() == 0) chk("rv0_spurious", 64'd1, 64'd0);
      else begin
        e = q0.pop_front();
        chk("rdata0", 64'(rdata0), 64'(e.data));
        chk("rd0_lat", 64'(cyc - e.gc), 64'(READ_LAT));
      end
    end
    if (rvalid1) begin
      rv1_cnt++;
      if (q1.size() == 0) chk("rv1_spurious", 64'd1, 64'd0);
      else begin
        e = q1.pop_front();
        chk("rdata1", 64'(rdata1), 64'(e.data));
        chk("rd1_lat", 64'(cyc - e.gc), 64'(READ_LAT));
      end
    end
  end

  // Present one access and wait for its grant; the caller presents the next access or drops req.
  task automatic acc(input int k, input logic [BE_W-1:0] we, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp, output int gc);
    int  n = 0;
    bit  got = 0;
    exp_t e;
    if (k == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if ((k == 0) ? gnt0 : gnt1) got = 1;
    end
    gc = cyc;
    chk("granted", 64'(got), 64'd1);
    if (got) begin
      chk("sram_ena", 64'(sram_ena), 64'd1);
      chk("sram_addra", 64'(sram_addra), 64'(a));
      chk("sram_wea", 64'(sram_wea), 64'(we));
      if (we != '0) chk("sram_dina", 64'(sram_dina), 64'(d));
      else begin
        e.data = exp;
        e.gc   = gc;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
  endtask

  task automatic drop(input int k);
    if (k == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  initial begin
    int g0, g1, g2, g3, s, e0, r0, r1;
    int gl[8];

    // Reset, then 5 idle cycles
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_ctrl", 64'({sram_ena, gnt0, gnt1, rvalid0, rvalid1}), 64'd0);
    end
    chk("idle_wea", 64'(sram_wea), 64'd0);
    chk("idle_addra", 64'(sram_addra), 64'd0);
    chk("idle_dina", 64'(sram_dina), 64'd0);
    chk("idle_rdata0", 64'(rdata0), 64'd0);
    chk("idle_rdata1", 64'(rdata1), 64'd0);

    // Host write then read-back, plus preloads for later tests
    r1 = rv1_cnt;
    acc(0, 4'hF, 14'h0010, 32'hDEADBEEF, 32'h0, g0);
    acc(0, 4'h0, 14'h0010, 32'h0, 32'hDEADBEEF, g1);
    acc(0, 4'hF, 14'h0001, 32'h11111111, 32'h0, g0);
    acc(0, 4'hF, 14'h0002, 32'h22222222, 32'h0, g0);
    acc(0, 4'hF, 14'h0030, 32'h12345678, 32'h0, g0);
    drop(0);
    repeat (4) @(negedge clk);
    chk("rv1_quiet", 64'(rv1_cnt - r1), 64'd0);
    chk("rdata0_hold", 64'(rdata0), 64'hDEADBEEF);

    // Simultaneous requests from reset: host, engine, host, engine
    rst = 1'b1;
    fork
      begin acc(0, 4'h0, 14'h0001, 32'h0, 32'h11111111, g0);
            acc(0, 4'h0, 14'h0001, 32'h0, 32'h11111111, g2); drop(0); end
      begin acc(1, 4'h0, 14'h0002, 32'h0, 32'h22222222, g1);
            acc(1, 4'h0, 14'h0002, 32'h0, 32'h22222222, g3); drop(1); end
      begin repeat (2) @(negedge clk); rst = 1'b0; end
    join
    chk("rr_e1", 64'(g1 - g0), 64'd1);
    chk("rr_h2", 64'(g2 - g0), 64'd2);
    chk("rr_e2", 64'(g3 - g0), 64'd3);
    repeat (4) @(negedge clk);

    // Engine partial write then read
    acc(1, 4'b0010, 14'h0030, 32'h0000AB00, 32'h0, g0);
    acc(1, 4'h0, 14'h0030, 32'h0, 32'h1234AB78, g1);
    drop(1);
    repeat (4) @(negedge clk);

    // Engine alone: one grant every second cycle
    s = ena_cnt;
    for (int i = 0; i < 8; i++) acc(1, 4'h0, 14'h0002, 32'h0, 32'h22222222, gl[i]);
    drop(1);
    repeat (4) @(negedge clk);
    for (int i = 1; i < 8; i++) chk("solo_gap", 64'(gl[i] - gl[i-1]), 64'd2);
    chk("solo_ena_cnt", 64'(ena_cnt - s), 64'd8);

    // Reset in the cycle after a read grant: the read must vanish
    acc(0, 4'h0, 14'h0001, 32'h0, 32'h11111111, g0);
    drop(0);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    r0 = rv0_cnt;
    r1 = rv1_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("flush_rv", 64'((rv0_cnt - r0) + (rv1_cnt - r1)), 64'd0);
    fork
      begin acc(0, 4'h0, 14'h0001, 32'h0, 32'h11111111, g0); drop(0); end
      begin acc(1, 4'h0, 14'h0002, 32'h0, 32'h22222222, g1); drop(1); end
    join
    chk("post_rst_tie", 64'(g0 < g1), 64'd1);
    repeat (6) @(negedge clk);
    e0 = q0.size() + q1.size();
    chk("sb_drained", 64'(e0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
